// File: rtl/alu_cmd_master.sv
// Command-port initiator for the TinyALU pin protocol: issues one op at a time on
// start/op/A/B and queues each result (or error marker) in an in-order response FIFO.
module alu_cmd_master #(
   parameter int TIMEOUT_CKS = 31,
   parameter int RES_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic        start,
   output logic [2:0]  op,
   output logic [7:0]  A,
   output logic [7:0]  B,
   input  logic        done,
   input  logic [15:0] result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_op,
   output logic        rsp_err,
   output logic        busy,
   output logic [7:0]  err_cnt
);
   localparam int AW = $clog2(RES_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   typedef enum logic [1:0] {IDLE, RUN, WAIT, RECOVER} state_t;
   typedef struct packed {
      logic [15:0] res;
      logic [2:0]  op;
      logic        err;
   } entry_t;

   state_t      state;
   logic [7:0]  tcnt;
   logic [2:0]  cur_op;
   logic        is_nop;
   logic        is_ill;
   entry_t      mem [RES_DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        full;
   logic        push;
   logic        pop;
   entry_t      push_data;
   entry_t      head;
   logic [1:0]  err_inc;
   logic [8:0]  err_sum;

   assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rsp_valid  = (wptr != rptr);
   assign pop        = rsp_valid && rsp_ready;
   assign head       = mem[rptr[AW-1:0]];
   assign rsp_result = head.res;
   assign rsp_op     = head.op;
   assign rsp_err    = head.err;
   assign cmd_ready  = (state == IDLE) && !full;
   assign err_sum    = {1'b0, err_cnt} + {7'b0, err_inc};

   // Response generation; done has priority over the timeout in the same cycle.
   always_comb begin
      push      = 1'b0;
      push_data = '0;
      err_inc   = 2'd0;
      case (state)
         RUN, WAIT: begin
            if (is_nop) begin
               push      = 1'b1;
               push_data = {16'h0000, 3'b000, 1'b0};
            end else if (done) begin
               push      = 1'b1;
               push_data = {result, cur_op, 1'b0};
            end else if (tcnt == TIMEOUT_CKS[7:0]) begin
               push      = 1'b1;
               push_data = {16'hFFFF, cur_op, 1'b1};
               err_inc   = 2'd1;
            end
         end
         RECOVER: begin
            if (is_ill) begin
               push      = 1'b1;
               push_data = {16'h0000, cur_op, 1'b1};
               err_inc   = 2'd1;
            end
         end
         default: ;
      endcase
      // A done pulse with nothing outstanding is counted as an error.
      if ((state == IDLE || state == RECOVER) && done)
         err_inc = err_inc + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         start   <= 1'b0;
         op      <= 3'b000;
         A       <= 8'h00;
         B       <= 8'h00;
         busy    <= 1'b0;
         err_cnt <= 8'h00;
         tcnt    <= 8'h00;
         cur_op  <= 3'b000;
         is_nop  <= 1'b0;
         is_ill  <= 1'b0;
      end else begin
         err_cnt <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cur_op <= cmd_op;
                  busy   <= 1'b1;
                  tcnt   <= 8'd1;
                  is_nop <= 1'b0;
                  is_ill <= 1'b0;
                  if (cmd_op > 3'b100) begin
                     is_ill <= 1'b1;
                     state  <= RECOVER;
                  end else begin
                     start  <= 1'b1;
                     op     <= cmd_op;
                     A      <= cmd_a;
                     B      <= cmd_b;
                     is_nop <= (cmd_op == 3'b000);
                     state  <= RUN;
                  end
               end
            end
            RUN, WAIT: begin
               if (push) begin
                  start <= 1'b0;
                  op    <= 3'b000;
                  state <= RECOVER;
               end else begin
                  tcnt  <= tcnt + 8'd1;
                  state <= WAIT;
               end
            end
            RECOVER: begin
               is_ill <= 1'b0;
               is_nop <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full)
            wptr <= wptr + PTR_ONE;
         if (pop)
            rptr <= rptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push && !full)
         mem[wptr[AW-1:0]] <= push_data;
   end
endmodule

// File: doc/alu_cmd_master.md
Name: alu_cmd_master

Overview:
- Synthesizable initiator for the TinyALU pin protocol (start/op/A/B in; done/result out).
- Accepts operations on a valid/ready command port and drives them onto the ALU pins.
- Captures each result into a response FIFO with valid/ready handshake.
- Lets the DUT be exercised on the FPGA without the behavioural driver and responder. Sits between the transaction link and the tinyalu instance.

Parameters:
- TIMEOUT_CKS, 31: maximum cycles start stays high waiting for done before abort (range 1..255).
- RES_DEPTH, 4: response FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  3  000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101–111 illegal.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- start  out  1  ALU start.
- op  out  3  ALU opcode.
- A  out  8  ALU operand A.
- B  out  8  ALU operand B.
- done  in  1  ALU done (one-cycle pulse).
- result  in  16  ALU result, valid when done=1.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer pops when rsp_valid && rsp_ready.
- rsp_result  out  16  result of head entry.
- rsp_op  out  3  opcode of head entry.
- rsp_err  out  1  head entry is illegal op or timeout.
- busy  out  1  FSM not IDLE.
- err_cnt  out  8  saturating count of errors and spurious done pulses.

Behaviour:
- Reset (clk edge with reset=1): state IDLE; start=0, op=0, A=0, B=0, rsp_valid=0, busy=0, err_cnt=0; FIFO flushed. Applies mid-operation: start drops on that edge and the in-flight op is discarded with no response.
- Outputs start/op/A/B/busy are registered. rsp_* are driven from the FIFO head.
- cmd_ready = (state==IDLE) && FIFO not full. Only one op is outstanding, so a FIFO slot is guaranteed at push time.
- States: IDLE, RUN, WAIT, RECOVER.
- IDLE, on handshake:
  - Latch op/A/B.
  - Legal non-NOP op: go RUN; start=1 from the next cycle.
  - NOP: start=1 for exactly one cycle with op=000, then RECOVER. Push {result 0, err 0} in the start cycle. Do not wait for done.
  - Illegal op: start stays 0 and pins are unchanged. Push {0, err 1} in the cycle after acceptance, increment err_cnt, go RECOVER.
- RUN/WAIT:
  - start held 1 and op/A/B held stable until done is sampled 1 or timeout.
  - Timeout counter starts at 1 in the first start-high cycle.
- done sampled 1 (WAIT/RUN): push {result, op, err 0}; start=0 next cycle; go RECOVER.
- Timeout (counter reaches TIMEOUT_CKS with done=0): push {16'hFFFF, op, err 1}; increment err_cnt; start=0 next cycle; go RECOVER.
- done and timeout in the same cycle: done wins (normal response).
- RECOVER: start=0 for exactly one cycle (guaranteed gap between ops), then IDLE. cmd_ready is 0 in RECOVER.
- done=1 while in IDLE or RECOVER: ignored for data, increments err_cnt.
- err_cnt saturates at 255.
- Latency: handshake at T → start=1 at T+1. done at cycle D → rsp_valid for that entry at D+1 (if FIFO was empty) → next cmd_ready at D+2.
- Back-to-back throughput: one op per (ALU latency + 3) cycles.
- FIFO:
  - Strictly in order.
  - Push and pop in the same cycle are both honoured.
  - Pop when empty is a no-op.
  - Head stable while rsp_valid && !rsp_ready.
  - Pointers wrap modulo RES_DEPTH with an extra bit for full/empty.
- A/B hold their last values while idle. op returns to 000 when start=0.

Test Plan:
- ADD A=8'h12 B=8'h34, DUT done 1 cycle after start → start high 2 cycles, rsp_result=16'h0046, rsp_op=001, rsp_err=0, start=0 the cycle after done.
- MUL A=8'hFF B=8'hFF, done 3 cycles after start → op/A/B stable throughout, rsp_result=16'hFE01, next cmd_ready exactly 2 cycles after done.
- NOP then op=3'b110 → NOP: start high exactly 1 cycle, rsp {0000, 000, err 0}. Illegal: start never asserted, rsp {0000, 110, err 1}, err_cnt=1.
- rsp_ready=0, push 5 ADDs (RES_DEPTH=4) → 4 accepted, cmd_ready stays 0. Assert rsp_ready → 4 results in order, then 5th accepted. Verify pointer wrap across 8+ ops.
- done tied 0, ADD issued → start high 31 cycles, rsp {FFFF, 001, err 1}, err_cnt=1. Separately: a done pulse in IDLE → err_cnt increments, FIFO unchanged.
- reset=1 during WAIT with 2 entries in FIFO → next edge start=0, rsp_valid=0, err_cnt=0. After release, a new XOR 8'hF0^8'h0F returns 16'h00FF.
